// File: rtl/cpu_pkg.sv
// Shared constants and types for the single-cycle RV32I-subset core.
// Also holds the built-in ROM program that runs when no program image is selected.
package cpu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NUM_REG = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // Decoded control for one instruction; all-zero means "retire as NOP".
  typedef struct packed {
    logic    reg_we;
    logic    mem_we;
    logic    use_imm;
    logic    is_branch;
    logic    is_jal;
    alu_op_e alu_op;
    wb_sel_e wb_sel;
  } ctrl_t;

  // Built-in program: computes a few values, round-trips one through RAM, then self-loops at 44.
  function automatic logic [31:0] default_rom(input int unsigned word);
    case (word)
      0:       return 32'h0050_0093; // addi x1,x0,5
      1:       return 32'h00A0_0113; // addi x2,x0,10
      2:       return 32'h0020_81B3; // add  x3,x1,x2
      3:       return 32'h4011_0233; // sub  x4,x2,x1
      4:       return 32'h0030_2023; // sw   x3,0(x0)
      5:       return 32'h0000_2283; // lw   x5,0(x0)
      6:       return 32'h0012_0463; // beq  x4,x1,+8
      7:       return 32'h0630_0313; // addi x6,x0,99
      8:       return 32'h0070_0313; // addi x6,x0,7
      9:       return 32'h0020_E3B3; // or   x7,x1,x2
      10:      return 32'h02A0_0513; // addi x10,x0,42
      11:      return 32'h0000_006F; // jal  x0,0
      default: return NOP_INSTR;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// 32 x XLEN register file: two combinational read ports, one clocked write port.
// x0 is hard-wired to zero; a read in the same cycle as a write sees the old value.
module regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data_c,
  output logic [XLEN-1:0]   rs2_data_c,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data
);

  logic [XLEN-1:0] registers [0:NUM_REG-1];

  always_comb begin
    rs1_data_c = (rs1_addr == '0) ? '0 : registers[rs1_addr];
    rs2_data_c = (rs2_addr == '0) ? '0 : registers[rs2_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REG; i++) begin
        registers[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      registers[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/riscv_cpu.sv
// Single-cycle RV32I-subset core: fetch, decode, execute and retire one instruction per clk.
// Holds PC, instruction ROM, data RAM, decoder, immediate generator, ALU and next-PC mux.
module riscv_cpu
  import cpu_pkg::*;
#(
  parameter int unsigned                 IMEM_WORDS = 64,
  parameter int unsigned                 DMEM_WORDS = 64,
  parameter string                       IMEM_FILE  = "",
  parameter logic [IMEM_WORDS*XLEN-1:0]  IMEM_IMAGE = '0
) (
  input logic clk,
  input logic reset
);

  localparam int unsigned IMEM_AW = $clog2(IMEM_WORDS);
  localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);
  // A named program file selects IMEM_IMAGE, the elaboration-time contents of that file.
  localparam bit          USE_IMAGE = (IMEM_FILE != "");

  logic [XLEN-1:0]    PC;
  logic [XLEN-1:0]    pc_d;
  logic [IMEM_AW-1:0] imem_idx;
  logic [XLEN-1:0]    instr;

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;

  ctrl_t           ctrl;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] wb_data;
  logic            rf_we;

  logic [DMEM_AW-1:0] dmem_idx;
  logic [XLEN-1:0]    load_data;
  logic [XLEN-1:0]    dmem [0:DMEM_WORDS-1];

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] pc_raw;
  logic            take_target;
  logic            unused_c;

  // Fetch
  assign imem_idx = PC[IMEM_AW+1:2];

  always_comb begin
    if (USE_IMAGE) begin
      instr = IMEM_IMAGE[32'(imem_idx)*XLEN +: XLEN];
    end else begin
      instr = default_rom(32'(imem_idx));
    end
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Sign-extended immediates for the I/S/B/J formats
  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Decode; anything not explicitly recognised leaves ctrl all-zero and retires as a NOP.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    ctrl.wb_sel = WB_ALU;
    case (opcode)
      OP_R: begin
        ctrl.reg_we = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD_SUB}: ctrl.alu_op = ALU_ADD;
          {F7_SUB,  F3_ADD_SUB}: ctrl.alu_op = ALU_SUB;
          {F7_BASE, F3_SLT}:     ctrl.alu_op = ALU_SLT;
          {F7_BASE, F3_OR}:      ctrl.alu_op = ALU_OR;
          {F7_BASE, F3_AND}:     ctrl.alu_op = ALU_AND;
          default:               ctrl.reg_we = 1'b0;
        endcase
      end
      OP_IMM: begin
        if (funct3 == F3_ADD_SUB) begin
          ctrl.reg_we  = 1'b1;
          ctrl.use_imm = 1'b1;
        end
      end
      OP_LOAD: begin
        if (funct3 == F3_WORD) begin
          ctrl.reg_we  = 1'b1;
          ctrl.use_imm = 1'b1;
          ctrl.wb_sel  = WB_MEM;
        end
      end
      OP_STORE: begin
        if (funct3 == F3_WORD) begin
          ctrl.mem_we  = 1'b1;
          ctrl.use_imm = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          ctrl.is_branch = 1'b1;
        end
      end
      OP_JAL: begin
        ctrl.reg_we = 1'b1;
        ctrl.is_jal = 1'b1;
        ctrl.wb_sel = WB_PC4;
      end
      default: ;
    endcase
  end

  regfile REGFILE (
    .clk        (clk),
    .reset      (reset),
    .rs1_addr   (rs1),
    .rs2_addr   (rs2),
    .rs1_data_c (rs1_val),
    .rs2_data_c (rs2_val),
    .wr_en      (rf_we),
    .wr_addr    (rd),
    .wr_data    (wb_data)
  );

  // ALU; stores use the S-format offset, every other immediate user the I-format one
  always_comb begin
    if (!ctrl.use_imm) begin
      alu_b = rs2_val;
    end else if (ctrl.mem_we) begin
      alu_b = imm_s;
    end else begin
      alu_b = imm_i;
    end
    case (ctrl.alu_op)
      ALU_ADD: alu_res = rs1_val + alu_b;
      ALU_SUB: alu_res = rs1_val - alu_b;
      ALU_AND: alu_res = rs1_val & alu_b;
      ALU_OR:  alu_res = rs1_val | alu_b;
      ALU_SLT: alu_res = XLEN'($signed(rs1_val) < $signed(alu_b));
      default: alu_res = '0;
    endcase
  end

  // Data RAM: word access, byte offset and address bits above the index are dropped
  assign dmem_idx  = alu_res[DMEM_AW+1:2];
  assign load_data = dmem[dmem_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        dmem[i] <= '0;
      end
    end else if (ctrl.mem_we) begin
      dmem[dmem_idx] <= rs2_val;
    end
  end

  // Writeback
  always_comb begin
    case (ctrl.wb_sel)
      WB_MEM:  wb_data = load_data;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_res;
    endcase
    rf_we = ctrl.reg_we && (rd != '0);
  end

  // Next PC: word-aligned and wrapped to the ROM size
  always_comb begin
    pc_plus4    = PC + XLEN'(4);
    pc_target   = PC + (ctrl.is_jal ? imm_j : imm_b);
    take_target = ctrl.is_jal || (ctrl.is_branch && (rs1_val == rs2_val));
    pc_raw      = take_target ? pc_target : pc_plus4;
    pc_d        = XLEN'({pc_raw[IMEM_AW+1:2], 2'b00});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC <= '0;
    end else begin
      PC <= pc_d;
    end
  end

  assign unused_c = ^{pc_raw[XLEN-1:IMEM_AW+2], pc_raw[1:0]};

endmodule

// File: tb/tb_riscv_cpu.sv
// Bench for riscv_cpu: four instances (built-in program plus three small images) checked
// against hand-computed architectural state, including async reset mid-run.
module tb_riscv_cpu;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // addi x0,x0,7 ; addi x1,x0,-1
  localparam logic [64*32-1:0] IMG1 = {{62{NOP}}, 32'hFFF0_0093, 32'h0070_0013};

  // addi x1,x0,3 ; beq x1,x0,+8 ; addi x2,x0,1 ; slt x3,x1,x0 ; addi x1,x0,-1 ;
  // slt x4,x1,x0 ; and x5,x1,x2 ; slt x6,x0,x1 ; sub x7,x0,x2 ; jal x0,0
  localparam logic [64*32-1:0] IMG2 = {{54{NOP}},
    32'h0000_006F, 32'h4020_03B3, 32'h0010_2333, 32'h0020_F2B3, 32'h0000_A233,
    32'hFFF0_0093, 32'h0000_A1B3, 32'h0010_0113, 32'h0000_8463, 32'h0030_0093};

  // addi x1,x0,9 ; 0xFFFFFFFF ; jal x5,+8 ; addi x6,x0,1 ; sw x1,-4(x0) ;
  // lw x7,252(x0) ; jal x0,0
  localparam logic [64*32-1:0] IMG3 = {{57{NOP}},
    32'h0000_006F, 32'h0FC0_2383, 32'hFE10_2E23, 32'h0010_0313, 32'h0080_02EF,
    32'hFFFF_FFFF, 32'h0090_0093};

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  riscv_cpu u_dut0 (.clk(clk), .reset(reset));
  riscv_cpu #(.IMEM_FILE("img1.hex"), .IMEM_IMAGE(IMG1)) u_dut1 (.clk(clk), .reset(reset));
  riscv_cpu #(.IMEM_FILE("img2.hex"), .IMEM_IMAGE(IMG2)) u_dut2 (.clk(clk), .reset(reset));
  riscv_cpu #(.IMEM_FILE("img3.hex"), .IMEM_IMAGE(IMG3)) u_dut3 (.clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // idx 0..31 = register, 32 = PC, 100+n = data RAM word n
  function automatic logic [31:0] rd_state(input int dut, input int idx);
    logic [31:0] v;
    v = '0;
    case (dut)
      0: if (idx < 32) v = u_dut0.REGFILE.registers[5'(idx)];
         else if (idx == 32) v = u_dut0.PC;
         else v = u_dut0.dmem[6'(idx - 100)];
      1: if (idx < 32) v = u_dut1.REGFILE.registers[5'(idx)];
         else if (idx == 32) v = u_dut1.PC;
         else v = u_dut1.dmem[6'(idx - 100)];
      2: if (idx < 32) v = u_dut2.REGFILE.registers[5'(idx)];
         else if (idx == 32) v = u_dut2.PC;
         else v = u_dut2.dmem[6'(idx - 100)];
      default: if (idx < 32) v = u_dut3.REGFILE.registers[5'(idx)];
         else if (idx == 32) v = u_dut3.PC;
         else v = u_dut3.dmem[6'(idx - 100)];
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int          dut;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t final_tbl[$];

  task automatic run_table(input string tag);
    foreach (final_tbl[i]) begin
      check($sformatf("%s_dut%0d_idx%0d", tag, final_tbl[i].dut, final_tbl[i].idx),
            rd_state(final_tbl[i].dut, final_tbl[i].idx), final_tbl[i].exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Final architectural state after the programs settle
    final_tbl.push_back('{0, 0,   32'd0});
    final_tbl.push_back('{0, 1,   32'd5});
    final_tbl.push_back('{0, 2,   32'd10});
    final_tbl.push_back('{0, 3,   32'd15});
    final_tbl.push_back('{0, 4,   32'd5});
    final_tbl.push_back('{0, 5,   32'd15});
    final_tbl.push_back('{0, 6,   32'd7});
    final_tbl.push_back('{0, 7,   32'd15});
    final_tbl.push_back('{0, 8,   32'd0});
    final_tbl.push_back('{0, 10,  32'd42});
    final_tbl.push_back('{0, 32,  32'd44});
    final_tbl.push_back('{0, 100, 32'd15});
    final_tbl.push_back('{1, 0,   32'd0});
    final_tbl.push_back('{1, 1,   32'hFFFF_FFFF});
    final_tbl.push_back('{2, 1,   32'hFFFF_FFFF});
    final_tbl.push_back('{2, 2,   32'd1});
    final_tbl.push_back('{2, 3,   32'd0});
    final_tbl.push_back('{2, 4,   32'd1});
    final_tbl.push_back('{2, 5,   32'd1});
    final_tbl.push_back('{2, 6,   32'd0});
    final_tbl.push_back('{2, 7,   32'hFFFF_FFFF});
    final_tbl.push_back('{2, 32,  32'd36});
    final_tbl.push_back('{3, 1,   32'd9});
    final_tbl.push_back('{3, 5,   32'd12});
    final_tbl.push_back('{3, 6,   32'd0});
    final_tbl.push_back('{3, 7,   32'd9});
    final_tbl.push_back('{3, 32,  32'd24});
    final_tbl.push_back('{3, 163, 32'd9});

    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    check("reset_pc", rd_state(0, 32), 32'd0);
    for (int r = 0; r < 32; r++) check($sformatf("reset_x%0d", r), rd_state(0, r), 32'd0);

    reset = 1'b1;
    @(negedge clk);
    check("first_edge_pc", rd_state(0, 32), 32'd4);
    check("first_edge_x1", rd_state(0, 1), 32'd5);
    check("first_edge_x2", rd_state(0, 2), 32'd0);

    // Undefined opcode at word 1 must only advance PC
    @(negedge clk);
    check("undef_pc", rd_state(3, 32), 32'd8);
    for (int r = 0; r < 32; r++)
      check($sformatf("undef_x%0d", r), rd_state(3, r), (r == 1) ? 32'd9 : 32'd0);
    check("undef_dmem63", rd_state(3, 163), 32'd0);

    repeat (18) @(negedge clk);
    run_table("run1");
    check("img1_pc", rd_state(1, 32), 32'd80);

    repeat (10) @(negedge clk);
    run_table("halt");

    // Restart, run partway, then pull reset between clock edges
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("midrun_pc", rd_state(0, 32), 32'd24);
    check("midrun_dmem0", rd_state(0, 100), 32'd15);
    check("midrun_x6", rd_state(0, 6), 32'd0);

    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_pc", rd_state(0, 32), 32'd0);
    for (int r = 0; r < 32; r++) check($sformatf("async_x%0d", r), rd_state(0, r), 32'd0);
    check("async_dmem0", rd_state(0, 100), 32'd0);

    repeat (2) @(negedge clk);
    check("held_pc", rd_state(0, 32), 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    run_table("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
